// File: rtl/reset_sequencer.sv
// Power-on / recovery reset sequencer: synchronises board reset and PLL lock,
// then releases NUM_STAGES reset domains in order, each gated by the previous stage's acknowledge.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_FILTER = 8,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rstIn,
  input  logic                  pllLocked,
  input  logic                  softRst,
  input  logic [NUM_STAGES-1:0] stageAck,
  output logic [NUM_STAGES-1:0] stageRstOut,
  output logic                  sysReady,
  output logic                  fault,
  output logic [3:0]            faultCount,
  output logic [2:0]            curStage
);

  localparam int MAX_A = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
  localparam int MAX_C = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {
    S_HOLD,
    S_LOCK_WAIT,
    S_DELAY,
    S_ACK,
    S_READY,
    S_FAULT
  } state_t;

  logic [1:0]            r_rstSync;
  logic [1:0]            r_lockSync;
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2:0]            r_cur;
  logic [NUM_STAGES-1:0] r_stageRst;
  logic                  r_sysReady;
  logic                  r_fault;
  logic [3:0]            r_faultCnt;

  state_t                w_state;
  logic [CNT_W-1:0]      w_cnt;
  logic [2:0]            w_cur;
  logic [NUM_STAGES-1:0] w_stageRst;
  logic                  w_sysReady;
  logic                  w_fault;
  logic [3:0]            w_faultCnt;
  logic                  w_rstDone;
  logic                  w_lockS;
  logic                  w_collapse;
  logic [IDX_W-1:0]      w_idx;

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_rstSync  <= '0;
      r_lockSync <= '0;
    end else begin
      r_rstSync  <= {r_rstSync[0], 1'b1};
      r_lockSync <= {r_lockSync[0], pllLocked};
    end
  end

  assign w_rstDone = r_rstSync[1];
  assign w_lockS   = r_lockSync[1];
  assign w_idx     = r_cur[IDX_W-1:0];

  // softRst wins over ack/timeout; lock loss only matters once sequencing has begun
  assign w_collapse = (softRst && (r_state != S_HOLD)) ||
                      (!w_lockS && ((r_state == S_DELAY) || (r_state == S_ACK) ||
                                    (r_state == S_READY)));

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_cur      = r_cur;
    w_stageRst = r_stageRst;
    w_sysReady = r_sysReady;
    w_fault    = r_fault;
    w_faultCnt = r_faultCnt;
    case (r_state)
      S_HOLD: begin
        w_cnt      = '0;
        w_cur      = '0;
        w_stageRst = '0;
        w_sysReady = 1'b0;
        if (w_rstDone) w_state = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (!w_lockS) begin
          w_cnt = '0;
        end else if (r_cnt == CNT_W'(LOCK_FILTER - 1)) begin
          w_cnt   = '0;
          w_state = S_DELAY;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DELAY: begin
        if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
          w_cnt             = '0;
          w_stageRst[w_idx] = 1'b1;
          w_state           = S_ACK;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_ACK: begin
        if (stageAck[w_idx]) begin
          w_cnt = '0;
          if (r_cur == 3'(NUM_STAGES - 1)) begin
            w_sysReady = 1'b1;
            w_state    = S_READY;
          end else begin
            w_cur   = r_cur + 3'd1;
            w_state = S_DELAY;
          end
        end else if ((ACK_TIMEOUT != 0) && (r_cnt == CNT_W'(ACK_TIMEOUT - 1))) begin
          w_cnt      = '0;
          w_stageRst = '0;
          w_state    = S_FAULT;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_READY: begin
        w_state = S_READY;
      end
      S_FAULT: begin
        w_fault = 1'b1;
        if (r_faultCnt != 4'hF) w_faultCnt = r_faultCnt + 4'd1;
        w_state = S_HOLD;
      end
      default: w_state = S_HOLD;
    endcase
    if (w_collapse) begin
      w_stageRst = '0;
      w_sysReady = 1'b0;
      w_cnt      = '0;
      w_cur      = '0;
      w_state    = S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      r_state    <= S_HOLD;
      r_cnt      <= '0;
      r_cur      <= '0;
      r_stageRst <= '0;
      r_sysReady <= 1'b0;
      r_fault    <= 1'b0;
      r_faultCnt <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_cur      <= w_cur;
      r_stageRst <= w_stageRst;
      r_sysReady <= w_sysReady;
      r_fault    <= w_fault;
      r_faultCnt <= w_faultCnt;
    end
  end

  assign stageRstOut = r_stageRst;
  assign sysReady    = r_sysReady;
  assign fault       = r_fault;
  assign faultCount  = r_faultCnt;
  assign curStage    = r_cur;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expectations queued as stimulus is applied,
// popped and asserted when the DUT output is observed.
module tb_reset_sequencer;

  localparam int NS = 3;
  localparam int LF = 8;
  localparam int SD = 16;
  localparam int AT = 1024;

  logic          clk = 1'b0;
  logic          rstIn;
  logic          pllLocked;
  logic          softRst;
  logic [NS-1:0] stageAck;
  logic [NS-1:0] stageRstOut;
  logic          sysReady;
  logic          fault;
  logic [3:0]    faultCount;
  logic [2:0]    curStage;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .LOCK_FILTER(LF),
    .STAGE_DELAY(SD),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk        (clk),
    .rstIn      (rstIn),
    .pllLocked  (pllLocked),
    .softRst    (softRst),
    .stageAck   (stageAck),
    .stageRstOut(stageRstOut),
    .sysReady   (sysReady),
    .fault      (fault),
    .faultCount (faultCount),
    .curStage   (curStage)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push_exp(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "scoreboard_empty";
      e.val = -999;
    end else begin
      e = sb.pop_front();
    end
    checks++;
    assert (obs === 32'(e.val)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({stageRstOut, sysReady, fault, faultCount, curStage});
  endfunction

  // mode 0: stageRstOut == val, mode 1: stageRstOut != val, mode 2: sysReady high
  task automatic wait_for(input int mode, input logic [2:0] val, input int budget,
                          output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if ((mode == 0 && stageRstOut == val) || (mode == 1 && stageRstOut != val) ||
          (mode == 2 && sysReady == 1'b1)) begin
        done = 1'b1;
      end else if (cyc >= budget) begin
        cyc  = -1;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int viol;
    rstIn     = 1'b0;
    pllLocked = 1'b1;
    softRst   = 1'b0;
    stageAck  = '1;

    // power-on reset and full release sequence
    repeat (2) @(negedge clk);
    push_exp("reset_outs_mid", 0);
    pop_check(outs());
    repeat (3) @(negedge clk);
    push_exp("reset_outs_end", 0);
    pop_check(outs());
    rstIn = 1'b1;
    push_exp("t1_stage0_released", 1);
    wait_for(0, 3'b001, 100, c);
    pop_check(32'(c >= 0));
    push_exp("t1_gap_stage1", SD + 1);
    wait_for(0, 3'b011, 100, c);
    pop_check(32'(c));
    push_exp("t1_gap_stage2", SD + 1);
    wait_for(0, 3'b111, 100, c);
    pop_check(32'(c));
    @(negedge clk);
    push_exp("t1_sysReady", 1);
    pop_check(32'(sysReady));
    push_exp("t1_fault", 0);
    pop_check(32'(fault));
    push_exp("t1_curStage", 2);
    pop_check(32'(curStage));

    // lock glitching never satisfies the filter
    pllLocked = 1'b0;
    repeat (5) @(negedge clk);
    push_exp("t2_collapse", 0);
    pop_check(32'({stageRstOut, sysReady}));
    viol = 0;
    for (int p = 0; p < 8; p++) begin
      pllLocked = 1'b0;
      @(negedge clk);
      if (stageRstOut != 3'b000) viol++;
      pllLocked = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (stageRstOut != 3'b000) viol++;
      end
    end
    push_exp("t2_no_release_while_glitching", 0);
    pop_check(32'(viol));
    push_exp("t2_release_after_filter", 2 + LF + SD - 4);
    wait_for(0, 3'b001, 100, c);
    pop_check(32'(c));

    // lock loss while waiting on stage 2 acknowledge
    stageAck = 3'b011;
    push_exp("t5_gap_to_stage2", 2 * (SD + 1));
    wait_for(0, 3'b111, 100, c);
    pop_check(32'(c));
    repeat (10) @(negedge clk);
    push_exp("t5_waiting_ack2", 2);
    pop_check(32'({sysReady, curStage}));
    pllLocked = 1'b0;
    push_exp("t5_collapse_latency", 3);
    wait_for(0, 3'b000, 20, c);
    pop_check(32'(c));
    push_exp("t5_sysReady_low", 0);
    pop_check(32'(sysReady));
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (stageRstOut != 3'b000) viol++;
    end
    push_exp("t5_held_while_unlocked", 0);
    pop_check(32'(viol));
    stageAck  = '1;
    pllLocked = 1'b1;
    push_exp("t5_restart_after_filter", 2 + LF + SD);
    wait_for(0, 3'b001, 100, c);
    pop_check(32'(c));
    push_exp("t5_ready_again", 1);
    wait_for(2, 3'b000, 100, c);
    pop_check(32'(c >= 0));

    // stage 1 never acknowledges: repeated timeouts, count saturates
    stageAck = 3'b101;
    softRst  = 1'b1;
    @(negedge clk);
    softRst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      push_exp("t3_reach_stage1", 1);
      wait_for(0, 3'b011, 200, c);
      pop_check(32'(c >= 0));
      push_exp("t3_timeout_cycles", AT);
      wait_for(1, 3'b011, AT + 50, c);
      pop_check(32'(c));
      push_exp("t3_collapsed", 0);
      pop_check(32'(stageRstOut));
      @(negedge clk);
      push_exp("t3_fault", 1);
      pop_check(32'(fault));
      push_exp("t3_faultCount", (i < 15) ? i : 15);
      pop_check(32'(faultCount));
    end

    // soft reset from READY keeps the fault record
    stageAck = '1;
    push_exp("t4_ready", 1);
    wait_for(2, 3'b000, 200, c);
    pop_check(32'(c >= 0));
    push_exp("t4_all_released", 7);
    pop_check(32'(stageRstOut));
    softRst = 1'b1;
    @(negedge clk);
    softRst = 1'b0;
    push_exp("t4_collapse", 0);
    pop_check(32'({stageRstOut, sysReady}));
    push_exp("t4_fault_kept", 1);
    pop_check(32'(fault));
    push_exp("t4_faultCount_kept", 15);
    pop_check(32'(faultCount));
    push_exp("t4_resequenced", 1);
    wait_for(2, 3'b000, 200, c);
    pop_check(32'(c >= 0));
    push_exp("t4_all_released_again", 7);
    pop_check(32'(stageRstOut));

    // asynchronous board reset in the middle of a stage delay
    softRst = 1'b1;
    @(negedge clk);
    softRst = 1'b0;
    push_exp("t6_stage0", 1);
    wait_for(0, 3'b001, 100, c);
    pop_check(32'(c >= 0));
    repeat (5) @(negedge clk);
    push_exp("t6_in_delay_stage1", 9);
    pop_check(32'({stageRstOut, curStage}));
    #2 rstIn = 1'b0;
    #1;
    push_exp("t6_async_reset_outs", 0);
    pop_check(outs());
    repeat (3) @(negedge clk);
    rstIn = 1'b1;
    push_exp("t6_restart_ready", 1);
    wait_for(2, 3'b000, 200, c);
    pop_check(32'(c >= 0));
    push_exp("t6_restart_stages", 7);
    pop_check(32'(stageRstOut));
    push_exp("t6_fault_cleared", 0);
    pop_check(32'({fault, faultCount}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
